lcd_bus_engine: RTL and testbench

Parametrised 8080-style parallel LCD bus master. It is the successor to the single-strobe LCD write controller.
- Accepts command/data words through a valid/ready push interface and buffers them in an internal FIFO.
- Generates the lcd_cs/lcd_wr/lcd_rs/lcd_data waveforms with programmable setup, strobe-low, strobe-high and CS-hold times.
- Keeps CS asserted across back-to-back words (burst mode).
- Sits between the AHB LCD register slave and the panel pins.

---
 rtl/lcd_bus_engine_if.sv | 33 +++
 rtl/lcd_bus_engine.sv | 193 +++++++++++++++++++
 tb/tb_lcd_bus_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_engine_if.sv
// Push-side, read-return and panel-pin signals of the 8080-style LCD bus engine.
// master = command source / panel model, slave = lcd_bus_engine.
interface lcd_bus_engine_if #(
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rs;
    logic          cmd_rd;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          lcd_cs;
    logic          lcd_wr;
    logic          lcd_rd;
    logic          lcd_rs;
    logic [DW-1:0] lcd_data;
    logic          lcd_data_oe;
    logic [DW-1:0] lcd_data_i;

    modport master (
        output cmd_valid, cmd_rs, cmd_rd, cmd_data, lcd_data_i,
        input  cmd_ready, busy, rd_valid, rd_data,
               lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_data, lcd_data_oe
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_rd, cmd_data, lcd_data_i,
        output cmd_ready, busy, rd_valid, rd_data,
               lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_data, lcd_data_oe
    );
endinterface

// File: rtl/lcd_bus_engine.sv
// 8080-style parallel LCD bus master with command FIFO and burst chip-select.
// Optional read cycles are compiled in with `define LCD_CTRL_READ_EN.
module lcd_bus_engine #(
    parameter int DW        = 16,
    parameter int DEPTH     = 4,
    parameter int T_SETUP   = 1,
    parameter int T_WR_LOW  = 2,
    parameter int T_WR_HIGH = 2,
    parameter int T_CS_HOLD = 1,
    parameter int T_RD_LOW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    lcd_bus_engine_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX = max2(max2(T_SETUP, T_WR_LOW),
                               max2(max2(T_WR_HIGH, T_CS_HOLD), T_RD_LOW));
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, WR_LOW, WR_HIGH, RD_LOW, HOLD} state_t;
    typedef struct packed {
        logic          rd;
        logic          rs;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, word_done;
    entry_t        head;
    logic          cs_q, cs_d, wr_q, wr_d, rs_q, rs_d, busy_q, busy_d;
    logic [DW-1:0] data_q, data_d;
`ifdef LCD_CTRL_READ_EN
    logic          cur_rd_q, cur_rd_d, rdn_q, rdn_d, oe_q, oe_d, rd_cap, rdv_q;
    logic [DW-1:0] rdd_q;
`endif

    assign head          = mem_q[rptr_q];
    assign bus.cmd_ready = (count_q != (AW+1)'(DEPTH));
    assign push          = bus.cmd_valid & bus.cmd_ready;
    assign count_d       = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign busy_d        = (state_d != IDLE) || (count_d != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.cmd_rd, bus.cmd_rs, bus.cmd_data};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        word_done = 1'b0;
        rs_d      = rs_q;
        data_d    = data_q;
`ifdef LCD_CTRL_READ_EN
        cur_rd_d  = cur_rd_q;
        oe_d      = oe_q;
        rd_cap    = 1'b0;
`endif
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop     = 1'b1;
                state_d = SETUP;
                cnt_d   = CW'(T_SETUP - 1);
            end
            SETUP: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
`ifdef LCD_CTRL_READ_EN
            else if (cur_rd_q) begin
                state_d = RD_LOW;
                cnt_d   = CW'(T_RD_LOW - 1);
            end
`endif
            else begin
                state_d = WR_LOW;
                cnt_d   = CW'(T_WR_LOW - 1);
            end
            WR_LOW: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else begin
                state_d = WR_HIGH;
                cnt_d   = CW'(T_WR_HIGH - 1);
            end
            WR_HIGH: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else word_done = 1'b1;
`ifdef LCD_CTRL_READ_EN
            RD_LOW: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else begin
                word_done = 1'b1;
                rd_cap    = 1'b1;
            end
`endif
            HOLD: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Back-to-back words keep CS low; only an empty FIFO ends the burst.
        if (word_done) begin
            if (count_q != '0) begin
                pop     = 1'b1;
                state_d = SETUP;
                cnt_d   = CW'(T_SETUP - 1);
            end else begin
                state_d = HOLD;
                cnt_d   = CW'(T_CS_HOLD - 1);
            end
        end

        if (pop) begin
            rs_d   = head.rs;
            data_d = head.data;
`ifdef LCD_CTRL_READ_EN
            cur_rd_d = head.rd;
            oe_d     = ~head.rd;
`endif
        end
`ifdef LCD_CTRL_READ_EN
        if (state_d == IDLE) oe_d = 1'b1;
        rdn_d = (state_d != RD_LOW);
`endif
        cs_d = (state_d == IDLE);
        wr_d = (state_d != WR_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            rs_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    assign bus.lcd_cs   = cs_q;
    assign bus.lcd_wr   = wr_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;
    assign bus.busy     = busy_q;

`ifdef LCD_CTRL_READ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_rd_q <= 1'b0;
            rdn_q    <= 1'b1;
            oe_q     <= 1'b1;
            rdv_q    <= 1'b0;
            rdd_q    <= '0;
        end else begin
            cur_rd_q <= cur_rd_d;
            rdn_q    <= rdn_d;
            oe_q     <= oe_d;
            rdv_q    <= rd_cap;
            if (rd_cap) rdd_q <= bus.lcd_data_i;
        end
    end

    assign bus.lcd_rd      = rdn_q;
    assign bus.lcd_data_oe = oe_q;
    assign bus.rd_valid    = rdv_q;
    assign bus.rd_data     = rdd_q;
`else
    logic unused_rd;
    assign unused_rd       = ^{head.rd, bus.lcd_data_i};
    assign bus.lcd_rd      = 1'b1;
    assign bus.lcd_data_oe = 1'b1;
    assign bus.rd_valid    = 1'b0;
    assign bus.rd_data     = '0;
`endif
endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine: default-timing instance A and all-ones-timing instance B.
module tb_lcd_bus_engine;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_bus_engine_if #(.DW(DW)) ifa ();
    lcd_bus_engine_if #(.DW(DW)) ifb ();

    lcd_bus_engine #(.DW(DW), .DEPTH(4), .T_SETUP(1), .T_WR_LOW(2), .T_WR_HIGH(2),
                     .T_CS_HOLD(1), .T_RD_LOW(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    lcd_bus_engine #(.DW(DW), .DEPTH(4), .T_SETUP(1), .T_WR_LOW(1), .T_WR_HIGH(1),
                     .T_CS_HOLD(1), .T_RD_LOW(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, actual=timeout required=event", name);
    endtask

    // Per-cycle trace of the selected instance, sampled on the falling edge.
    logic rec_en  = 1'b0;
    int   rec_sel = 0;
    logic q_cs[$], q_wr[$], q_rd[$], q_rs[$], q_oe[$], q_rdv[$];
    logic [DW-1:0] q_data[$], q_rdd[$];

    always @(negedge clk) begin
        if (rec_en) begin
            q_cs.push_back(rec_sel == 0 ? ifa.lcd_cs : ifb.lcd_cs);
            q_wr.push_back(rec_sel == 0 ? ifa.lcd_wr : ifb.lcd_wr);
            q_rd.push_back(rec_sel == 0 ? ifa.lcd_rd : ifb.lcd_rd);
            q_rs.push_back(rec_sel == 0 ? ifa.lcd_rs : ifb.lcd_rs);
            q_oe.push_back(rec_sel == 0 ? ifa.lcd_data_oe : ifb.lcd_data_oe);
            q_rdv.push_back(rec_sel == 0 ? ifa.rd_valid : ifb.rd_valid);
            q_data.push_back(rec_sel == 0 ? ifa.lcd_data : ifb.lcd_data);
            q_rdd.push_back(rec_sel == 0 ? ifa.rd_data : ifb.rd_data);
        end
    end

    task automatic rec_start(input int sel);
        q_cs.delete(); q_wr.delete(); q_rd.delete(); q_rs.delete();
        q_oe.delete(); q_rdv.delete(); q_data.delete(); q_rdd.delete();
        rec_sel = sel;
        rec_en  = 1'b1;
    endtask

    int a_cs_low, a_cs_runs, a_wr_low, a_rd_low, a_oe_low, a_rdv, a_viol, a_rd_oe_bad;
    int a_rd_last, a_rdv_idx;
    int a_wr_start[$];
    logic [DW-1:0] a_wr_data[$];
    logic a_wr_rs[$];
    logic [DW-1:0] a_rdv_data, a_rdd_any;

    task automatic analyze();
        logic pcs, pwr, prs;
        logic [DW-1:0] pdata;
        a_cs_low = 0; a_cs_runs = 0; a_wr_low = 0; a_rd_low = 0; a_oe_low = 0;
        a_rdv = 0; a_viol = 0; a_rd_oe_bad = 0; a_rd_last = -1; a_rdv_idx = -1;
        a_rdv_data = '0; a_rdd_any = '0;
        a_wr_start.delete(); a_wr_data.delete(); a_wr_rs.delete();
        pcs = 1'b1; pwr = 1'b1; prs = 1'b0; pdata = '0;
        for (int i = 0; i < q_cs.size(); i++) begin
            if (!q_cs[i]) begin
                a_cs_low++;
                if (pcs) a_cs_runs++;
            end
            if (!q_wr[i]) begin
                a_wr_low++;
                if (pwr) begin
                    a_wr_start.push_back(i);
                    a_wr_data.push_back(q_data[i]);
                    a_wr_rs.push_back(q_rs[i]);
                end else if (q_data[i] !== pdata || q_rs[i] !== prs) begin
                    a_viol++;
                end
            end
            if (!q_rd[i]) begin
                a_rd_low++;
                a_rd_last = i;
                if (q_oe[i]) a_rd_oe_bad++;
            end
            if (!q_oe[i]) a_oe_low++;
            if (q_rdv[i]) begin
                a_rdv++;
                a_rdv_idx  = i;
                a_rdv_data = q_rdd[i];
            end
            a_rdd_any = a_rdd_any | q_rdd[i];
            pcs = q_cs[i]; pwr = q_wr[i]; prs = q_rs[i]; pdata = q_data[i];
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic rd, input logic rs,
                         input logic [DW-1:0] d);
        if (sel == 0) begin
            ifa.cmd_valid = v; ifa.cmd_rd = rd; ifa.cmd_rs = rs; ifa.cmd_data = d;
        end else begin
            ifb.cmd_valid = v; ifb.cmd_rd = rd; ifb.cmd_rs = rs; ifb.cmd_data = d;
        end
    endtask

    logic          w_rd [8];
    logic          w_rs [8];
    logic [DW-1:0] w_data [8];

    // Consecutive pushes, one per cycle; callers only use this while the FIFO has room.
    task automatic push_words(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, w_rd[i], w_rs[i], w_data[i]);
        end
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_idle(input int sel, input string name);
        int g;
        g = 0;
        while (((sel == 0) ? ifa.busy : ifb.busy) !== 1'b0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic          rs;
        logic [DW-1:0] data;
        logic [7:0]    exp_cs;
        logic [7:0]    exp_wr;
        logic [7:0]    exp_busy;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, stall, first_stall, guard;
        logic r;

        // Samples start on the cycle after the accepting edge.
        vecs[0] = '{1'b0, 16'h002C, 8'b1000_0001, 8'b1100_1111, 8'b1111_1110};
        vecs[1] = '{1'b1, 16'h1234, 8'b1000_0001, 8'b1100_1111, 8'b1111_1110};
        vecs[2] = '{1'b1, 16'hFFFF, 8'b1000_0001, 8'b1100_1111, 8'b1111_1110};
        vecs[3] = '{1'b0, 16'h0000, 8'b1000_0001, 8'b1100_1111, 8'b1111_1110};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0);
        ifa.lcd_data_i = 16'hA5A5;
        ifb.lcd_data_i = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cs", ifa.lcd_cs, 1);
        check("rst_wr", ifa.lcd_wr, 1);
        check("rst_rd", ifa.lcd_rd, 1);
        check("rst_rs", ifa.lcd_rs, 0);
        check("rst_data", ifa.lcd_data, 0);
        check("rst_oe", ifa.lcd_data_oe, 1);
        check("rst_rd_valid", ifa.rd_valid, 0);
        check("rst_rd_data", ifa.rd_data, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_ready", ifa.cmd_ready, 1);

        // Single writes: exact waveform shape.
        for (int v = 0; v < 4; v++) begin
            logic [7:0] ocs, owr, obusy;
            int bad;
            bad = 0;
            @(negedge clk);
            drive(0, 1'b1, 1'b0, vecs[v].rs, vecs[v].data);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (i == 0) drive(0, 1'b0, 1'b0, 1'b0, '0);
                ocs   = {ocs[6:0], ifa.lcd_cs};
                owr   = {owr[6:0], ifa.lcd_wr};
                obusy = {obusy[6:0], ifa.busy};
                if (!ifa.lcd_cs && (ifa.lcd_rs !== vecs[v].rs || ifa.lcd_data !== vecs[v].data))
                    bad++;
            end
            check($sformatf("t1_cs_v%0d", v), ocs, vecs[v].exp_cs);
            check($sformatf("t1_wr_v%0d", v), owr, vecs[v].exp_wr);
            check($sformatf("t1_busy_v%0d", v), obusy, vecs[v].exp_busy);
            check($sformatf("t1_rs_data_v%0d", v), bad, 0);
            wait_idle(0, $sformatf("t1_idle_v%0d", v));
        end

        // Burst of three.
        w_rd[0] = 0; w_rs[0] = 0; w_data[0] = 16'h002C;
        w_rd[1] = 0; w_rs[1] = 1; w_data[1] = 16'h1234;
        w_rd[2] = 0; w_rs[2] = 1; w_data[2] = 16'h5678;
        rec_start(0);
        push_words(0, 3);
        wait_idle(0, "t2_idle");
        rec_en = 1'b0;
        analyze();
        check("t2_cs_low", a_cs_low, 16);
        check("t2_cs_runs", a_cs_runs, 1);
        check("t2_pulses", a_wr_start.size(), 3);
        check("t2_wr_low", a_wr_low, 6);
        check("t2_stable", a_viol, 0);
        if (a_wr_start.size() == 3) begin
            check("t2_space1", a_wr_start[1] - a_wr_start[0], 5);
            check("t2_space2", a_wr_start[2] - a_wr_start[1], 5);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t2_data%0d", i), a_wr_data[i], w_data[i]);
                check($sformatf("t2_rs%0d", i), a_wr_rs[i], w_rs[i]);
            end
        end

        // Backpressure: six words with cmd_valid held.
        for (int i = 0; i < 6; i++) begin
            w_rd[i] = 0; w_rs[i] = i[0]; w_data[i] = 16'h0100 + 16'(i);
        end
        rec_start(0);
        k = 0; stall = 0; first_stall = -1; guard = 0;
        @(negedge clk);
        drive(0, 1'b1, w_rd[0], w_rs[0], w_data[0]);
        r = ifa.cmd_ready;
        while (k < 6 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (r) begin
                k++;
                if (k < 6) drive(0, 1'b1, w_rd[k], w_rs[k], w_data[k]);
                else drive(0, 1'b0, 1'b0, 1'b0, '0);
            end else begin
                stall++;
            end
            if (!ifa.cmd_ready && first_stall < 0) first_stall = k;
            r = ifa.cmd_ready;
        end
        if (guard >= 200) timeout_fail("t3_push");
        wait_idle(0, "t3_idle");
        rec_en = 1'b0;
        analyze();
        check("t3_accepted_before_stall", first_stall, 5);
        check("t3_stall_cycles", stall, 2);
        check("t3_pulses", a_wr_start.size(), 6);
        check("t3_cs_low", a_cs_low, 31);
        check("t3_cs_runs", a_cs_runs, 1);
        check("t3_stable", a_viol, 0);
        if (a_wr_start.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("t3_data%0d", i), a_wr_data[i], w_data[i]);
        end

        // Reset during WR_LOW with two words queued.
        w_rd[0] = 0; w_rs[0] = 1; w_data[0] = 16'hAAAA;
        w_rd[1] = 0; w_rs[1] = 1; w_data[1] = 16'hBBBB;
        w_rd[2] = 0; w_rs[2] = 1; w_data[2] = 16'hCCCC;
        push_words(0, 3);
        guard = 0;
        while (ifa.lcd_wr !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout_fail("t4_wr_low");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_cs", ifa.lcd_cs, 1);
        check("t4_wr", ifa.lcd_wr, 1);
        check("t4_ready", ifa.cmd_ready, 1);
        check("t4_busy", ifa.busy, 0);
        check("t4_data", ifa.lcd_data, 0);
        rec_start(0);
        repeat (20) @(negedge clk);
        rec_en = 1'b0;
        analyze();
        check("t4_no_cs_after", a_cs_low, 0);
        check("t4_no_wr_after", a_wr_low, 0);

        // Minimum timing on instance B.
        w_rd[0] = 0; w_rs[0] = 0; w_data[0] = 16'h0011;
        w_rd[1] = 0; w_rs[1] = 1; w_data[1] = 16'h0022;
        w_rd[2] = 0; w_rs[2] = 1; w_data[2] = 16'h0033;
        w_rd[3] = 0; w_rs[3] = 0; w_data[3] = 16'h0044;
        rec_start(1);
        push_words(1, 4);
        wait_idle(1, "t5_idle");
        rec_en = 1'b0;
        analyze();
        check("t5_cs_low", a_cs_low, 13);
        check("t5_cs_runs", a_cs_runs, 1);
        check("t5_pulses", a_wr_start.size(), 4);
        check("t5_wr_low", a_wr_low, 4);
        if (a_wr_start.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check($sformatf("t5_space%0d", i), a_wr_start[i] - a_wr_start[i-1], 3);
            for (int i = 0; i < 4; i++)
                check($sformatf("t5_data%0d", i), a_wr_data[i], w_data[i]);
        end

        // Read word on instance A.
        w_rd[0] = 1; w_rs[0] = 1; w_data[0] = 16'h1111;
        rec_start(0);
        push_words(0, 1);
        wait_idle(0, "t6_idle");
        rec_en = 1'b0;
        analyze();
        check("t6_cs_low", a_cs_low, 6);
`ifdef LCD_CTRL_READ_EN
        check("t6_rd_low", a_rd_low, 4);
        check("t6_oe_low", a_oe_low, 6);
        check("t6_oe_during_rd", a_rd_oe_bad, 0);
        check("t6_wr_pulses", a_wr_start.size(), 0);
        check("t6_rd_valid_count", a_rdv, 1);
        check("t6_rd_data", a_rdv_data, 16'hA5A5);
        check("t6_rd_valid_pos", a_rdv_idx - a_rd_last, 1);
        check("t6_rd_data_any", a_rdd_any, 16'hA5A5);
`else
        check("t6_wr_pulses", a_wr_start.size(), 1);
        check("t6_wr_low", a_wr_low, 2);
        check("t6_rd_low", a_rd_low, 0);
        check("t6_oe_low", a_oe_low, 0);
        check("t6_oe_during_rd", a_rd_oe_bad, 0);
        check("t6_rd_valid_count", a_rdv, 0);
        check("t6_rd_valid_pos", a_rdv_idx - a_rd_last, 0);
        check("t6_rd_data_any", a_rdd_any, 0);
        check("t6_rd_data", a_rdv_data, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
